// File: rtl/id_stage.sv
// Instruction decode stage for a 5-stage MIPS-subset pipeline.
// Decodes the IF/ID word, detects load-use hazards against the instruction
// currently in ID/EX, and loads the ID/EX register with either the decoded
// instruction or a bubble. A sticky illegal flag and a saturating stall
// counter report status.
module id_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  input  logic [31:0]            if_instr,
  input  logic [31:0]            if_pc4,
  input  logic                   flush,
  output logic [4:0]             reg_1,
  output logic [4:0]             reg_2,
  input  logic [31:0]            reg_1_data,
  input  logic [31:0]            reg_2_data,
  output logic                   id_stall,
  output logic                   ex_valid,
  output logic [31:0]            ex_pc4,
  output logic [31:0]            ex_rs_data,
  output logic [31:0]            ex_rt_data,
  output logic [31:0]            ex_imm,
  output logic [4:0]             ex_rs,
  output logic [4:0]             ex_rt,
  output logic [4:0]             ex_dest,
  output logic                   ex_reg_write,
  output logic                   ex_mem_read,
  output logic                   ex_mem_write,
  output logic                   ex_mem_to_reg,
  output logic                   ex_alu_src,
  output logic                   ex_branch,
  output logic [2:0]             ex_alu_op,
  output logic                   illegal_instr,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // ID/EX pipeline register contents; an all-zero value is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch;
    alu_op_e     alu_op;
  } id_ex_t;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] unused_shamt;

  id_ex_t dec;
  id_ex_t ex_d;
  id_ex_t ex_q;
  logic   legal;
  logic   rt_src;
  logic   load_use;
  logic   issue;
  logic   set_illegal;

  assign op           = if_instr[31:26];
  assign rs           = if_instr[25:21];
  assign rt           = if_instr[20:16];
  assign rd           = if_instr[15:11];
  assign unused_shamt = if_instr[10:6];
  assign funct        = if_instr[5:0];

  // Register file is addressed straight from the instruction word so the
  // read data is ready by the next rising edge.
  assign reg_1 = rs;
  assign reg_2 = rt;

  // Decode op/funct into ID/EX control; legal/rt_src stay 0 for unsupported encodings.
  always_comb begin
    dec         = '0;
    legal       = 1'b0;
    rt_src      = 1'b0;
    dec.valid   = 1'b1;
    dec.pc4     = if_pc4;
    dec.rs_data = reg_1_data;
    dec.rt_data = reg_2_data;
    dec.imm     = {{16{if_instr[15]}}, if_instr[15:0]};
    dec.rs      = rs;
    dec.rt      = rt;
    unique case (op)
      OP_RTYPE: begin
        dec.dest      = rd;
        dec.reg_write = 1'b1;
        unique case (funct)
          FN_ADD:  begin legal = 1'b1; rt_src = 1'b1; dec.alu_op = ALU_ADD; end
          FN_SUB:  begin legal = 1'b1; rt_src = 1'b1; dec.alu_op = ALU_SUB; end
          FN_AND:  begin legal = 1'b1; rt_src = 1'b1; dec.alu_op = ALU_AND; end
          FN_OR:   begin legal = 1'b1; rt_src = 1'b1; dec.alu_op = ALU_OR;  end
          FN_SLT:  begin legal = 1'b1; rt_src = 1'b1; dec.alu_op = ALU_SLT; end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        legal          = 1'b1;
        dec.dest       = rt;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        legal         = 1'b1;
        rt_src        = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        legal      = 1'b1;
        rt_src     = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        legal         = 1'b1;
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

  // Load-use hazard: the load in ID/EX writes a register this instruction reads.
  // Once a bubble replaces the load the condition drops, so a stall lasts one cycle.
  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.dest != 5'd0) & if_valid &
                    ((ex_q.dest == rs) | (rt_src & (ex_q.dest == rt)));

  // Flush kills the instruction anyway, so there is nothing to hold.
  assign id_stall    = load_use & ~flush;
  assign issue       = if_valid & ~flush & ~load_use & legal;
  assign set_illegal = if_valid & ~flush & ~legal;
  assign ex_d        = issue ? dec : '0;

  // ID/EX register plus sticky illegal flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      illegal_instr <= 1'b0;
      stall_count   <= '0;
    end else begin
      ex_q <= ex_d;
      if (set_illegal)
        illegal_instr <= 1'b1;
      if (id_stall && (stall_count != {STALL_CNT_W{1'b1}}))
        stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc4        = ex_q.pc4;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_branch     = ex_q.branch;
  assign ex_alu_op     = ex_q.alu_op;

endmodule
